// File: rtl/led_row_scanner.sv
// Row-multiplexed driver for a 16x16 red/green LED matrix: captures a frame into a
// shadow buffer, then scans it one row at a time with a blanking gap before each row.
module led_row_scanner #(
  parameter int unsigned ROW_DWELL = 1000,
  parameter int unsigned BLANK_CYC = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [15:0][15:0]  RedPixels,
  input  logic [15:0][15:0]  GrnPixels,
  output logic [15:0]        RowSel,
  output logic [15:0]        RedCol,
  output logic [15:0]        GrnCol,
  output logic               FrameStart,
  output logic               FrameDone
);

  localparam int unsigned CntMax = (ROW_DWELL > BLANK_CYC) ? ROW_DWELL : BLANK_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(ROW_DWELL - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_row, w_row_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [15:0][15:0] r_shr, r_shg;
  logic              w_latch;
  logic              w_start_d, w_done_d;
  logic [15:0]       r_row_sel, w_row_sel_d;
  logic [15:0]       r_red_col, w_red_col_d;
  logic [15:0]       r_grn_col, w_grn_col_d;
  logic              r_frame_start, r_frame_done;

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_cnt_d   = r_cnt;
    w_latch   = 1'b0;
    w_start_d = 1'b0;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (EN) begin
          w_latch   = 1'b1;
          w_start_d = 1'b1;
          w_row_d   = 4'd0;
          w_cnt_d   = '0;
          w_state_d = StBlank;
        end
      end
      StBlank: begin
        if (!EN) begin
          w_state_d = StIdle;
          w_row_d   = 4'd0;
          w_cnt_d   = '0;
        end else if (r_cnt == BlankLast) begin
          w_cnt_d   = '0;
          w_state_d = StDrive;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDrive: begin
        if (!EN) begin
          w_state_d = StIdle;
          w_row_d   = 4'd0;
          w_cnt_d   = '0;
        end else if (r_cnt == DwellLast) begin
          w_cnt_d   = '0;
          w_state_d = StBlank;
          if (r_row == 4'd15) begin
            // Wrap: frame boundary, re-latch so the next frame is tear-free
            w_row_d   = 4'd0;
            w_latch   = 1'b1;
            w_start_d = 1'b1;
            w_done_d  = 1'b1;
          end else begin
            w_row_d = r_row + 4'd1;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_row_d   = 4'd0;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe
  always_comb begin
    w_row_sel_d = 16'h0000;
    w_red_col_d = 16'h0000;
    w_grn_col_d = 16'h0000;
    if (w_state_d == StDrive) begin
      w_row_sel_d = 16'h0001 << w_row_d;
      w_red_col_d = r_shr[w_row_d];
      w_grn_col_d = r_shg[w_row_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= StIdle;
      r_row         <= 4'd0;
      r_cnt         <= '0;
      r_shr         <= '0;
      r_shg         <= '0;
      r_row_sel     <= 16'h0000;
      r_red_col     <= 16'h0000;
      r_grn_col     <= 16'h0000;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_row         <= w_row_d;
      r_cnt         <= w_cnt_d;
      if (w_latch) begin
        r_shr <= RedPixels;
        r_shg <= GrnPixels;
      end
      r_row_sel     <= w_row_sel_d;
      r_red_col     <= w_red_col_d;
      r_grn_col     <= w_grn_col_d;
      r_frame_start <= w_start_d;
      r_frame_done  <= w_done_d;
    end
  end

  assign RowSel     = r_row_sel;
  assign RedCol     = r_red_col;
  assign GrnCol     = r_grn_col;
  assign FrameStart = r_frame_start;
  assign FrameDone  = r_frame_done;

endmodule

// File: tb/tb_led_row_scanner.sv
// Bench for led_row_scanner: reset/start vector table, directed corner sequences and
// randomized traffic checked against a frame-time reference model.
module tb_led_row_scanner;

  localparam int Dwell = 4;
  localparam int Blank = 2;
  localparam int Slot  = Dwell + Blank;
  localparam int Frame = 16 * Slot;

  logic              clk;
  logic              rst_r;
  logic              en_r;
  logic [15:0][15:0] red_px;
  logic [15:0][15:0] grn_px;
  logic [15:0]       row_sel, red_col, grn_col;
  logic              frame_start, frame_done;

  led_row_scanner #(
    .ROW_DWELL(Dwell),
    .BLANK_CYC(Blank)
  ) dut (
    .CLK       (clk),
    .RST       (rst_r),
    .EN        (en_r),
    .RedPixels (red_px),
    .GrnPixels (grn_px),
    .RowSel    (row_sel),
    .RedCol    (red_col),
    .GrnCol    (grn_col),
    .FrameStart(frame_start),
    .FrameDone (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame plus a copy of the latched frame
  bit          m_run;
  int          m_t;
  logic [15:0] m_shr [16];
  logic [15:0] m_shg [16];
  logic        m_fs, m_fd;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] rs;
    logic [15:0] rc;
    logic [15:0] gc;
    logic        fs;
    logic        fd;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_latch();
    for (int i = 0; i < 16; i++) begin
      m_shr[i] = red_px[i];
      m_shg[i] = grn_px[i];
    end
  endtask

  task automatic model_edge();
    m_fs = 1'b0;
    m_fd = 1'b0;
    if (rst_r) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      if (en_r) begin
        m_run = 1'b1;
        m_t   = 0;
        m_fs  = 1'b1;
        model_latch();
      end
    end else if (!en_r) begin
      m_run = 1'b0;
    end else begin
      m_t++;
      if (m_t == Frame) begin
        m_t  = 0;
        m_fs = 1'b1;
        m_fd = 1'b1;
        model_latch();
      end
    end
  endtask

  function automatic bit m_driving();
    return m_run && ((m_t % Slot) >= Blank);
  endfunction

  task automatic check_model();
    logic [15:0] e_rs, e_rc, e_gc;
    e_rs = 16'h0000;
    e_rc = 16'h0000;
    e_gc = 16'h0000;
    if (m_driving()) begin
      e_rs = 16'h0001 << (m_t / Slot);
      e_rc = m_shr[m_t / Slot];
      e_gc = m_shg[m_t / Slot];
    end
    chk("RowSel", row_sel, e_rs);
    chk("RedCol", red_col, e_rc);
    chk("GrnCol", grn_col, e_gc);
    chk("FrameStart", 16'(frame_start), 16'(m_fs));
    chk("FrameDone", 16'(frame_done), 16'(m_fd));
  endtask

  task automatic step(input logic rst, input logic en);
    @(negedge clk);
    rst_r = rst;
    en_r  = en;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Scanning steps until the model reaches frame time tgt; bounded
  task automatic run_to(input int tgt);
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b1);
      check_model();
      n++;
    end while (!(m_run && m_t == tgt) && n < 2 * Frame);
    if (!(m_run && m_t == tgt)) begin
      errors++;
      $display("FAIL run_to timeout: got t=%0d expected t=%0d", m_t, tgt);
    end
  endtask

  initial begin
    int last_done;
    m_run  = 1'b0;
    m_t    = 0;
    m_fs   = 1'b0;
    m_fd   = 1'b0;
    rst_r  = 1'b1;
    en_r   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      red_px[i] = 16'hFFFF;
      grn_px[i] = 16'hFFFF;
      m_shr[i]  = 16'h0000;
      m_shg[i]  = 16'h0000;
    end

    // Reset held with EN=1 and all-ones frames, then release and scan the first rows
    tbl[0]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h0002, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 16'h0002, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].rst, tbl[k].en);
      chk("tbl RowSel", row_sel, tbl[k].rs);
      chk("tbl RedCol", red_col, tbl[k].rc);
      chk("tbl GrnCol", grn_col, tbl[k].gc);
      chk("tbl FrameStart", 16'(frame_start), 16'(tbl[k].fs));
      chk("tbl FrameDone", 16'(frame_done), 16'(tbl[k].fd));
    end

    // Green-only constant rows, latched at the next wrap, one full frame
    for (int i = 0; i < 16; i++) begin
      red_px[i] = 16'h0000;
      grn_px[i] = 16'h52AA;
    end
    run_to(0);
    for (int c = 1; c < Frame; c++) begin
      step(1'b0, 1'b1);
      check_model();
      if (m_driving()) chk("green row", grn_col, 16'h52AA);
    end

    // Row-unique red pattern; FrameDone/FrameStart must coincide every Frame clocks
    for (int i = 0; i < 16; i++) begin
      red_px[i] = 16'h0001 << i;
      grn_px[i] = 16'h0000;
    end
    last_done = -1;
    for (int c = 0; c < 2 * Frame + 1; c++) begin
      step(1'b0, 1'b1);
      check_model();
      if (row_sel != 16'h0000) chk("red follows row", red_col, row_sel);
      if (frame_done) begin
        chk("start with done", 16'(frame_start), 16'h0001);
        if (last_done >= 0) chk("frame period", 16'(c - last_done), 16'(Frame));
        last_done = c;
      end
    end

    // Mid-frame input change: no tearing until the wrap
    run_to(40);
    for (int i = 0; i < 16; i++) red_px[i] = 16'hA5A5;
    run_to(15 * Slot + Blank);
    chk("row15 old data", red_col, 16'h8000);
    run_to(Blank);
    chk("row0 new data", red_col, 16'hA5A5);

    // Drop EN during row 9 drive, then restart at row 0
    run_to(9 * Slot + Blank + 1);
    step(1'b0, 1'b0);
    check_model();
    chk("drop rowsel", row_sel, 16'h0000);
    chk("drop no done", 16'(frame_done), 16'h0000);
    step(1'b0, 1'b1);
    check_model();
    chk("restart start", 16'(frame_start), 16'h0001);
    run_to(Blank);
    chk("restart row0", row_sel, 16'h0001);

    // Reset on the row-15 final dwell cycle suppresses the wrap pulses
    run_to(Frame - 1);
    step(1'b1, 1'b1);
    check_model();
    chk("rst no done", 16'(frame_done), 16'h0000);
    chk("rst no start", 16'(frame_start), 16'h0000);
    chk("rst rowsel", row_sel, 16'h0000);
    step(1'b0, 1'b0);
    check_model();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < 16; i++) begin
          red_px[i] = 16'($urandom);
          grn_px[i] = 16'($urandom);
        end
      end
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 63) != 0));
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
